// File: rtl/dbus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dbus_bridge_pkg
// Shared CPU data-bus parameters: bus widths, lane constants, the bridge FSM
// state encoding, the default read data returned after a bus timeout, and a
// helper that sizes the timeout counter.
//
// Configuration macro seen by users of this package: DBUS_TIMEOUT_EN
// (enables the WAIT-state timeout in dbus_bridge).
// -----------------------------------------------------------------------------
package dbus_bridge_pkg;

   // Bus constants
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   // Read data presented to the datapath when a memory access is aborted
   localparam logic [DATA_W-1:0] DBUS_ERR_DATA = 32'hDEADBEEF;

   // Narrowest timeout counter the bridge will ever build
   localparam int TIMEOUT_CNT_MIN_W = 8;

   // Bridge FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } dbus_state_t;

   // Counter width able to hold values up to 'limit', never below the minimum
   function automatic int timeout_cnt_w(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < TIMEOUT_CNT_MIN_W) ? TIMEOUT_CNT_MIN_W : w;
   endfunction

endpackage

// File: rtl/dbus_bridge_timeout.sv
// -----------------------------------------------------------------------------
// dbus_timeout
// WAIT-state watchdog for dbus_bridge. Only built when the macro
// DBUS_TIMEOUT_EN is defined; the default build contains nothing here.
//
// Ports
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   clear   in  1  zero the counter (asserted when a request enters WAIT)
//   run     in  1  count this cycle (bridge is in WAIT)
//   expire  out 1  high during the WAIT cycle that completes LIMIT cycles
// -----------------------------------------------------------------------------
`ifdef DBUS_TIMEOUT_EN
module dbus_timeout
   import dbus_bridge_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = timeout_cnt_w(LIMIT);

   // The count holds the number of WAIT cycles already completed, so the
   // LIMIT-th WAIT cycle is the one where the count equals LIMIT-1.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = run && (count == LAST);

endmodule
`endif

// File: rtl/dbus_bridge.sv
// -----------------------------------------------------------------------------
// dbus_bridge
// Stalls the CPU data port while a single access is carried out on a slow
// request/acknowledge memory. A request seen in IDLE stalls the CPU in that
// same cycle, latches the access fields and waits for iMemAck. After the ack
// one DONE cycle releases the stall and presents the read data; DONE always
// returns to IDLE so the finishing instruction's still-asserted enable does
// not start a second access.
//
// Optional feature: define DBUS_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles; reads then return ERR_DATA and oBusError latches.
// Without the macro WAIT ends only on iMemAck and oBusError is constant 0.
//
// Ports
//   iCLK          in  1       clock, rising edge
//   iRST          in  1       asynchronous active-high reset
//   iReadEnable   in  1       CPU load request
//   iWriteEnable  in  1       CPU store request (wins over a load)
//   iByteEnable   in  4       CPU byte lanes
//   iAddress      in  ADDR_W  CPU address
//   iWriteData    in  32      CPU store data
//   oReadData     out 32      last captured load data
//   oStall        out 1       hold PC and register-file writes this cycle
//   oMemReq       out 1       memory request, held until acknowledged
//   oMemWe        out 1       latched write flag
//   oMemBe        out 4       latched byte lanes
//   oMemAddr      out ADDR_W  latched address
//   oMemWdata     out 32      latched store data
//   iMemAck       in  1       one-cycle completion pulse
//   iMemRdata     in  32      memory data, valid with iMemAck
//   oBusError     out 1       sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module dbus_bridge
   import dbus_bridge_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_DATA       = DBUS_ERR_DATA
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iReadEnable,
   input  logic              iWriteEnable,
   input  logic [BE_W-1:0]   iByteEnable,
   input  logic [ADDR_W-1:0] iAddress,
   input  logic [DATA_W-1:0] iWriteData,
   output logic [DATA_W-1:0] oReadData,
   output logic              oStall,
   output logic              oMemReq,
   output logic              oMemWe,
   output logic [BE_W-1:0]   oMemBe,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemWdata,
   input  logic              iMemAck,
   input  logic [DATA_W-1:0] iMemRdata,
   output logic              oBusError
);

   // Reject a timeout limit that could never be reached
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("dbus_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   dbus_state_t       state;
   logic              start;
   logic              timeout_hit;
   logic              mem_req;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] read_data;
   logic              bus_error;

   assign start = (state == ST_IDLE) && (iReadEnable || iWriteEnable);

`ifdef DBUS_TIMEOUT_EN
   dbus_timeout #(
      .LIMIT  (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (iCLK),
      .rst    (iRST),
      .clear  (start),
      .run    (state == ST_WAIT),
      .expire (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Access FSM. The request fields and read data are registers owned by the
   // FSM; an ack takes priority over a timeout expiring in the same cycle.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= ST_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         read_data <= '0;
         bus_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mem_req   <= 1'b1;
                  mem_we    <= iWriteEnable;   // read+write together is a write
                  mem_be    <= iByteEnable;
                  mem_addr  <= iAddress;
                  mem_wdata <= iWriteData;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (iMemAck) begin
                  if (!mem_we) begin
                     read_data <= iMemRdata;
                  end
                  mem_req <= 1'b0;
                  state   <= ST_DONE;
               end else if (timeout_hit) begin
                  if (!mem_we) begin
                     read_data <= ERR_DATA;
                  end
                  bus_error <= 1'b1;
                  mem_req   <= 1'b0;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   // The stall must rise in the request cycle itself, before any register
   // can react, so it is decoded from the state and the live enables.
   assign oStall    = (state == ST_WAIT) || start;
   assign oMemReq   = mem_req;
   assign oMemWe    = mem_we;
   assign oMemBe    = mem_be;
   assign oMemAddr  = mem_addr;
   assign oMemWdata = mem_wdata;
   assign oReadData = read_data;
   assign oBusError = bus_error;

endmodule

// File: tb/tb_dbus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dbus_bridge
// Directed bench for dbus_bridge. The memory side is driven per cycle by the
// bench; expected values are hand-computed constants. When DBUS_TIMEOUT_EN
// is defined the DUT is built with TIMEOUT_CYCLES=4 and the abort path is
// exercised; otherwise a long WAIT must complete normally.
// -----------------------------------------------------------------------------
module tb_dbus_bridge;
   import dbus_bridge_pkg::*;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iReadEnable;
   logic        iWriteEnable;
   logic [3:0]  iByteEnable;
   logic [31:0] iAddress;
   logic [31:0] iWriteData;
   logic [31:0] oReadData;
   logic        oStall;
   logic        oMemReq;
   logic        oMemWe;
   logic [3:0]  oMemBe;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWdata;
   logic        iMemAck;
   logic [31:0] iMemRdata;
   logic        oBusError;

   int n_total = 0;
   int n_bad   = 0;

   dbus_bridge #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (4),
      .ERR_DATA       (32'hDEADBEEF)
   ) dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .iReadEnable  (iReadEnable),
      .iWriteEnable (iWriteEnable),
      .iByteEnable  (iByteEnable),
      .iAddress     (iAddress),
      .iWriteData   (iWriteData),
      .oReadData    (oReadData),
      .oStall       (oStall),
      .oMemReq      (oMemReq),
      .oMemWe       (oMemWe),
      .oMemBe       (oMemBe),
      .oMemAddr     (oMemAddr),
      .oMemWdata    (oMemWdata),
      .iMemAck      (iMemAck),
      .iMemRdata    (iMemRdata),
      .oBusError    (oBusError)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs must all be at their reset values
   task automatic chk_reset(input string tag);
      chk({tag, "_stall"}, oStall,    1'b0);
      chk({tag, "_req"},   oMemReq,   1'b0);
      chk({tag, "_we"},    oMemWe,    1'b0);
      chk({tag, "_be"},    oMemBe,    4'h0);
      chk({tag, "_addr"},  oMemAddr,  32'h0);
      chk({tag, "_wdata"}, oMemWdata, 32'h0);
      chk({tag, "_rdata"}, oReadData, 32'h0);
      chk({tag, "_berr"},  oBusError, 1'b0);
   endtask

   // Starts at posedge+1 with the bridge idle. Holds the request until the
   // first non-stalled cycle (DONE) and returns at that cycle's negedge.
   // The memory acks in the ack_at-th WAIT cycle (0 = never).
   task automatic do_txn(input string tag, input logic re, input logic we,
                         input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at,
                         input logic [31:0] rdata,
                         output int stalls, output int bursts);
      int   waits;
      int   unstable;
      logic prev_req;
      bit   done;
      stalls   = 0;
      bursts   = 0;
      waits    = 0;
      unstable = 0;
      prev_req = 1'b0;
      done     = 1'b0;
      iReadEnable  = re;
      iWriteEnable = we;
      iByteEnable  = be;
      iAddress     = addr;
      iWriteData   = wdata;
      for (int n = 0; n < 40 && !done; n++) begin
         if (oMemReq) begin
            waits++;
         end
         iMemAck   = oMemReq && (waits == ack_at);
         iMemRdata = iMemAck ? rdata : 32'h0;
         @(negedge iCLK);
         if (oStall) stalls++;
         if (oMemReq && !prev_req) bursts++;
         if (oMemReq && (oMemAddr !== addr || oMemBe !== be)) unstable++;
         prev_req = oMemReq;
         if (!oStall && n > 0) begin
            done = 1'b1;
         end else begin
            @(posedge iCLK);
            #1;
         end
      end
      chk({tag, "_bound"}, done, 1'b1);
      chk({tag, "_stable"}, unstable, 0);
      $display("txn %s: re=%0b we=%0b addr=%08h stalls=%0d bursts=%0d rdata=%08h berr=%0b",
               tag, re, we, addr, stalls, bursts, oReadData, oBusError);
   endtask

   // Leave DONE: the held enables drop after the edge; the bridge must be
   // idle with no new request.
   task automatic end_txn(input string tag);
      @(posedge iCLK);
      #1;
      iReadEnable  = 1'b0;
      iWriteEnable = 1'b0;
      iMemAck      = 1'b0;
      @(negedge iCLK);
      chk({tag, "_idle_stall"}, oStall, 1'b0);
      chk({tag, "_idle_req"},   oMemReq, 1'b0);
      @(posedge iCLK);
      #1;
   endtask

   int stalls;
   int bursts;

   initial begin
      iRST         = 1'b1;
      iReadEnable  = 1'b0;
      iWriteEnable = 1'b0;
      iByteEnable  = 4'h0;
      iAddress     = 32'h0;
      iWriteData   = 32'h0;
      iMemAck      = 1'b0;
      iMemRdata    = 32'h0;
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      chk_reset("reset");
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      @(posedge iCLK);
      #1;

      // Read, ack in third WAIT cycle
      do_txn("rd", 1'b1, 1'b0, 4'hF, 32'h10010000, 32'h0, 3, 32'hCAFEBABE, stalls, bursts);
      chk("rd_stalls", stalls, 4);
      chk("rd_bursts", bursts, 1);
      chk("rd_data",   oReadData, 32'hCAFEBABE);
      chk("rd_we",     oMemWe, 1'b0);
      chk("rd_addr",   oMemAddr, 32'h10010000);
      chk("rd_req",    oMemReq, 1'b0);
      end_txn("rd");

      // Spurious ack while idle
      iMemAck   = 1'b1;
      iMemRdata = 32'h11111111;
      @(negedge iCLK);
      chk("spur_stall", oStall, 1'b0);
      chk("spur_req",   oMemReq, 1'b0);
      @(posedge iCLK);
      #1;
      iMemAck = 1'b0;
      @(negedge iCLK);
      chk("spur_rdata", oReadData, 32'hCAFEBABE);
      chk("spur_req2",  oMemReq, 1'b0);
      $display("txn spur: ack in idle rdata=%08h", oReadData);
      @(posedge iCLK);
      #1;

      // Write, immediate ack; read data must not change
      do_txn("wr", 1'b0, 1'b1, 4'b0011, 32'h10010004, 32'h12345678, 1, 32'h55555555, stalls, bursts);
      chk("wr_stalls", stalls, 2);
      chk("wr_bursts", bursts, 1);
      chk("wr_we",     oMemWe, 1'b1);
      chk("wr_be",     oMemBe, 4'b0011);
      chk("wr_addr",   oMemAddr, 32'h10010004);
      chk("wr_wdata",  oMemWdata, 32'h12345678);
      chk("wr_rdata",  oReadData, 32'hCAFEBABE);
      end_txn("wr");

      // Both enables: treated as a write, one transaction only
      do_txn("rw", 1'b1, 1'b1, 4'hF, 32'h10010008, 32'hA5A5A5A5, 2, 32'h77777777, stalls, bursts);
      chk("rw_stalls", stalls, 3);
      chk("rw_bursts", bursts, 1);
      chk("rw_we",     oMemWe, 1'b1);
      chk("rw_wdata",  oMemWdata, 32'hA5A5A5A5);
      chk("rw_rdata",  oReadData, 32'hCAFEBABE);
      end_txn("rw");

      // Ack in the 4th WAIT cycle: the cycle a 4-cycle timeout would expire
      do_txn("edge", 1'b1, 1'b0, 4'hF, 32'h1001000C, 32'h0, 4, 32'h13572468, stalls, bursts);
      chk("edge_stalls", stalls, 5);
      chk("edge_rdata",  oReadData, 32'h13572468);
      chk("edge_berr",   oBusError, 1'b0);
      end_txn("edge");

`ifdef DBUS_TIMEOUT_EN
      // No ack: abort after 4 WAIT cycles
      do_txn("tmo", 1'b1, 1'b0, 4'hF, 32'h10010010, 32'h0, 0, 32'h0, stalls, bursts);
      chk("tmo_stalls", stalls, 5);
      chk("tmo_bursts", bursts, 1);
      chk("tmo_rdata",  oReadData, 32'hDEADBEEF);
      chk("tmo_berr",   oBusError, 1'b1);
      end_txn("tmo");
      do_txn("post", 1'b1, 1'b0, 4'hF, 32'h10010014, 32'h0, 1, 32'h24681357, stalls, bursts);
      chk("post_rdata", oReadData, 32'h24681357);
      chk("post_berr",  oBusError, 1'b1);
      end_txn("post");
`else
      // Long WAIT completes normally with no error
      do_txn("long", 1'b1, 1'b0, 4'hF, 32'h10010010, 32'h0, 10, 32'h2468ACE0, stalls, bursts);
      chk("long_stalls", stalls, 11);
      chk("long_bursts", bursts, 1);
      chk("long_rdata",  oReadData, 32'h2468ACE0);
      chk("long_berr",   oBusError, 1'b0);
      end_txn("long");
`endif

      // Reset pulsed in the middle of WAIT
      iReadEnable = 1'b1;
      iAddress    = 32'h10010020;
      iByteEnable = 4'hF;
      @(posedge iCLK);
      #1;
      chk("rst_pre_req", oMemReq, 1'b1);
      @(posedge iCLK);
      #2;
      iRST        = 1'b1;
      iReadEnable = 1'b0;
      #1;
      chk_reset("rst_mid");
      $display("txn rst: reset during WAIT req=%0b stall=%0b", oMemReq, oStall);
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      @(posedge iCLK);
      #1;

      // Normal access after reset
      do_txn("arst", 1'b0, 1'b1, 4'b1100, 32'h10010024, 32'hFEEDFACE, 1, 32'h0, stalls, bursts);
      chk("arst_stalls", stalls, 2);
      chk("arst_bursts", bursts, 1);
      chk("arst_be",     oMemBe, 4'b1100);
      chk("arst_addr",   oMemAddr, 32'h10010024);
      chk("arst_rdata",  oReadData, 32'h0);
      chk("arst_berr",   oBusError, 1'b0);
      end_txn("arst");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dbus_bridge.md
DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, address width of CPU and memory sides.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, cycles to wait for iMemAck before abort (used only with DBUS_TIMEOUT_EN).
REQ-003 Parameter ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-004 iCLK  in  1  sole clock; all state on rising edge.
REQ-005 iRST  in  1  reset, asynchronous, active-high.
REQ-006 iReadEnable  in  1  CPU data read request (datapath DwReadEnable).
REQ-007 iWriteEnable  in  1  CPU data write request (datapath DwWriteEnable).
REQ-008 iByteEnable  in  4  CPU byte lanes.
REQ-009 iAddress  in  ADDR_W  CPU data address.
REQ-010 iWriteData  in  32  CPU store data.
REQ-011 oReadData  out  32  load data to datapath DwReadData.
REQ-012 oStall  out  1  high = CPU must hold PC and register-file writes this cycle.
REQ-013 oMemReq  out  1  request to slow memory; held until acknowledged.
REQ-014 oMemWe / oMemBe / oMemAddr / oMemWdata  out  1/4/ADDR_W/32  latched request fields.
REQ-015 iMemAck  in  1  one-cycle memory completion pulse.
REQ-016 iMemRdata  in  32  memory read data, valid when iMemAck high.
REQ-017 oBusError  out  1  sticky timeout flag.

Function
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 IDLE: if iReadEnable or iWriteEnable, oStall shall be 1 combinationally in that same cycle; request fields latched; next state WAIT.
REQ-020 iReadEnable and iWriteEnable both high shall be treated as a write (oMemWe=1).
REQ-021 WAIT: oMemReq=1, oStall=1, latched fields stable; on iMemAck capture iMemRdata (reads only) into the read-data register, next DONE.
REQ-022 DONE: oStall=0 and oMemReq=0 for exactly one cycle; oReadData shows captured data; next IDLE unconditionally, so the still-present request of the finishing instruction is not reissued.
REQ-023 Minimum access latency: 2 stall cycles (request cycle + ack in first WAIT cycle), then DONE.
REQ-024 oReadData shall hold its last captured value at all times outside capture; writes shall not modify it.
REQ-025 iMemAck in IDLE or DONE shall be ignored.
REQ-026 IDLE with no request: oStall=0, oMemReq=0.

Reset
REQ-027 iRST shall force IDLE asynchronously, including mid-WAIT; the pending request is dropped, not replayed.
REQ-028 Reset values: oStall=0, oMemReq=0, oMemWe=0, oMemBe=0, oMemAddr=0, oMemWdata=0, oReadData=0, oBusError=0, timeout counter=0.

Configuration
REQ-029 Macro DBUS_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on entry to WAIT, incremented each WAIT cycle; on reaching TIMEOUT_CYCLES without ack, go DONE, oReadData=ERR_DATA for reads, oBusError set (cleared only by iRST).
REQ-030 Ack in the same cycle the count reaches TIMEOUT_CYCLES shall win (normal completion, no error).
REQ-031 Macro not defined: no counter; WAIT is left only on iMemAck; oBusError tied 0.

Structure
REQ-032 State encoding (IDLE/WAIT/DONE) and ERR_DATA default shall reside in the shared CPU parameters package alongside the existing bus constants.
REQ-033 Single flat module; the timeout counter may be a sub-module dbus_timeout, instantiated only under DBUS_TIMEOUT_EN.

Verification
REQ-034 Read addr 0x10010000, ack after 3 WAIT cycles with 0xCAFEBABE -> oStall high 4 cycles, DONE shows 0xCAFEBABE, one oMemReq burst.
REQ-035 Write 0x12345678, BE=4'b0011 to 0x10010004, ack immediately -> oMemWe=1, oMemBe=0011, oStall high 2 cycles, oReadData unchanged.
REQ-036 Read+write enables both high -> oMemWe=1; request held through DONE -> exactly one transaction issued.
REQ-037 iRST pulsed during WAIT -> oMemReq/oStall fall asynchronously, all outputs at reset values, next request works normally.
REQ-038 DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 WAIT cycles, oReadData=0xDEADBEEF, oBusError=1 and stays 1.
REQ-039 Spurious iMemAck while IDLE -> no state change, oReadData unchanged.
